// File: rtl/aximm_test_sequencer.sv
// Self-contained AVMM master that sequences the AXI-MM-over-AIB self-test.
// Optional capture/compare of the first/last data words: define AXIMM_SEQ_DATA_CAPTURE_EN.
module aximm_test_sequencer #(
  parameter logic [31:0] DELAY_X    = 32'h0000000C,
  parameter logic [31:0] DELAY_Y    = 32'h00000020,
  parameter logic [31:0] DELAY_Z    = 32'h00001770,
  parameter logic [31:0] XFER_ADDR  = 32'h10000000,
  parameter logic [31:0] XFER_CFG   = 32'h00041804,
  parameter int          POLL_GAP   = 16,
  parameter int          POLL_LIMIT = 4096
) (
  input  logic        avmm_clk,
  input  logic        avmm_rst,
  input  logic        i_start,
  output logic [31:0] o_address,
  output logic        o_write,
  output logic        o_read,
  output logic [31:0] o_writedata,
  input  logic        i_waitrequest,
  input  logic        i_readdatavalid,
  input  logic [31:0] i_readdata,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_pass,
  output logic        o_timeout,
`ifdef AXIMM_SEQ_DATA_CAPTURE_EN
  output logic [63:0] o_dout_first,
  output logic [63:0] o_dout_last,
  output logic [63:0] o_din_first,
  output logic [63:0] o_din_last,
`endif
  output logic [3:0]  o_status
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_WR_X      = 4'd1;
  localparam logic [3:0] S_WR_Y      = 4'd2;
  localparam logic [3:0] S_WR_Z      = 4'd3;
  localparam logic [3:0] S_POLL_LINK = 4'd4;
  localparam logic [3:0] S_WR_XA     = 4'd5;
  localparam logic [3:0] S_WR_WCFG   = 4'd6;
  localparam logic [3:0] S_POLL_WR   = 4'd7;
  localparam logic [3:0] S_WR_RA     = 4'd8;
  localparam logic [3:0] S_WR_RCFG   = 4'd9;
  localparam logic [3:0] S_POLL_RD   = 4'd10;
  localparam logic [3:0] S_RD_STS    = 4'd11;
  localparam logic [3:0] S_DONE      = 4'd12;
`ifdef AXIMM_SEQ_DATA_CAPTURE_EN
  localparam logic [3:0] S_CAP_WR    = 4'd13;
  localparam logic [3:0] S_CAP_RD    = 4'd14;
`endif

  // Sub-phase of every read-type state: command, awaiting response, inter-poll gap.
  localparam logic [1:0] PH_CMD  = 2'd0;
  localparam logic [1:0] PH_RESP = 2'd1;
  localparam logic [1:0] PH_GAP  = 2'd2;

  localparam int CNT_W = $clog2(POLL_LIMIT + 1);
  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [CNT_W-1:0] LIMIT_V  = CNT_W'(POLL_LIMIT);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);

  logic [3:0]       state;
  logic [1:0]       ph;
  logic [CNT_W-1:0] poll_cnt;
  logic [CNT_W-1:0] poll_cnt_nxt;
  logic [GAP_W-1:0] gap_cnt;
  logic [31:0]      cmd_addr;
  logic [31:0]      cmd_data;
  logic             is_wr_state;
  logic             is_rd_state;
  logic             poll_met;
  logic [3:0]       poll_next;
  logic [3:0]       wr_next;
  logic             grade;
  logic             unused_rd;

`ifdef AXIMM_SEQ_DATA_CAPTURE_EN
  logic [1:0] cap_idx;
`endif

  assign unused_rd    = ^i_readdata[31:6];
  assign poll_cnt_nxt = poll_cnt + 1'b1;

  always_comb begin
    cmd_addr    = 32'h0;
    cmd_data    = 32'h0;
    is_wr_state = 1'b0;
    is_rd_state = 1'b0;
    wr_next     = S_IDLE;
    case (state)
      S_WR_X:      begin cmd_addr = 32'h50002000; cmd_data = DELAY_X;   is_wr_state = 1'b1; wr_next = S_WR_Y;      end
      S_WR_Y:      begin cmd_addr = 32'h50002004; cmd_data = DELAY_Y;   is_wr_state = 1'b1; wr_next = S_WR_Z;      end
      S_WR_Z:      begin cmd_addr = 32'h50002008; cmd_data = DELAY_Z;   is_wr_state = 1'b1; wr_next = S_POLL_LINK; end
      S_WR_XA:     begin cmd_addr = 32'h50001004; cmd_data = XFER_ADDR; is_wr_state = 1'b1; wr_next = S_WR_WCFG;   end
      S_WR_WCFG:   begin cmd_addr = 32'h50001000; cmd_data = XFER_CFG;  is_wr_state = 1'b1; wr_next = S_POLL_WR;   end
      S_WR_RA:     begin cmd_addr = 32'h50001004; cmd_data = XFER_ADDR; is_wr_state = 1'b1; wr_next = S_WR_RCFG;   end
      S_WR_RCFG:   begin cmd_addr = 32'h50001010; cmd_data = XFER_CFG;  is_wr_state = 1'b1; wr_next = S_POLL_RD;   end
      S_POLL_LINK: begin cmd_addr = 32'h5000100C; is_rd_state = 1'b1; end
      S_POLL_WR,
      S_POLL_RD,
      S_RD_STS:    begin cmd_addr = 32'h50001008; is_rd_state = 1'b1; end
`ifdef AXIMM_SEQ_DATA_CAPTURE_EN
      S_CAP_WR:    begin cmd_addr = 32'h50004000 | {27'd0, cap_idx[1], 1'b0, cap_idx[0], 2'b00}; is_rd_state = 1'b1; end
      S_CAP_RD:    begin cmd_addr = 32'h50004020 | {27'd0, cap_idx[1], 1'b0, cap_idx[0], 2'b00}; is_rd_state = 1'b1; end
`endif
      default:     ;
    endcase
  end

  always_comb begin
    poll_met  = 1'b0;
    poll_next = S_DONE;
    case (state)
      S_POLL_LINK: begin poll_met = (i_readdata[3:0] == 4'hF); poll_next = S_WR_XA; end
`ifdef AXIMM_SEQ_DATA_CAPTURE_EN
      S_POLL_WR:   begin poll_met = i_readdata[4]; poll_next = S_CAP_WR; end
      S_POLL_RD:   begin poll_met = i_readdata[5]; poll_next = S_CAP_RD; end
`else
      S_POLL_WR:   begin poll_met = i_readdata[4]; poll_next = S_WR_RA;  end
      S_POLL_RD:   begin poll_met = i_readdata[5]; poll_next = S_RD_STS; end
`endif
      default:     ;
    endcase
  end

`ifdef AXIMM_SEQ_DATA_CAPTURE_EN
  assign grade = (i_readdata[3:0] == 4'hF) &&
                 (o_dout_first == o_din_first) && (o_dout_last == o_din_last);
`else
  assign grade = (i_readdata[3:0] == 4'hF);
`endif

  assign o_write     = is_wr_state;
  assign o_read      = is_rd_state && (ph == PH_CMD);
  assign o_address   = (o_write || o_read) ? cmd_addr : 32'h0;
  assign o_writedata = o_write ? cmd_data : 32'h0;
  assign o_busy      = (state != S_IDLE) && (state != S_DONE);
  assign o_done      = (state == S_DONE);

  always_ff @(posedge avmm_clk or posedge avmm_rst) begin
    if (avmm_rst) begin
      state     <= S_IDLE;
      ph        <= PH_CMD;
      poll_cnt  <= '0;
      gap_cnt   <= '0;
      o_pass    <= 1'b0;
      o_timeout <= 1'b0;
      o_status  <= 4'h0;
`ifdef AXIMM_SEQ_DATA_CAPTURE_EN
      cap_idx      <= 2'd0;
      o_dout_first <= 64'h0;
      o_dout_last  <= 64'h0;
      o_din_first  <= 64'h0;
      o_din_last   <= 64'h0;
`endif
    end else begin
      if (state == S_IDLE) begin
        if (i_start) begin
          o_pass    <= 1'b0;
          o_timeout <= 1'b0;
          o_status  <= 4'h0;
          poll_cnt  <= '0;
          ph        <= PH_CMD;
          state     <= S_WR_X;
        end
      end else if (state == S_DONE) begin
        state <= S_IDLE;
      end else if (is_wr_state) begin
        if (!i_waitrequest) begin
          poll_cnt <= '0;
          state    <= wr_next;
        end
      end else begin
        case (ph)
          PH_CMD:  if (!i_waitrequest) ph <= PH_RESP;
          PH_GAP: begin
            if (gap_cnt == GAP_LAST) begin
              gap_cnt <= '0;
              ph      <= PH_CMD;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
          default: begin
            // Only a response that belongs to our single outstanding read is consumed.
            if (i_readdatavalid) begin
              ph <= PH_CMD;
              if (state == S_RD_STS) begin
                o_status <= i_readdata[3:0];
                o_pass   <= grade;
                state    <= S_DONE;
`ifdef AXIMM_SEQ_DATA_CAPTURE_EN
              end else if (state == S_CAP_WR || state == S_CAP_RD) begin
                case ({state == S_CAP_RD, cap_idx})
                  3'b000:  o_dout_first[31:0]  <= i_readdata;
                  3'b001:  o_dout_first[63:32] <= i_readdata;
                  3'b010:  o_dout_last[31:0]   <= i_readdata;
                  3'b011:  o_dout_last[63:32]  <= i_readdata;
                  3'b100:  o_din_first[31:0]   <= i_readdata;
                  3'b101:  o_din_first[63:32]  <= i_readdata;
                  3'b110:  o_din_last[31:0]    <= i_readdata;
                  default: o_din_last[63:32]   <= i_readdata;
                endcase
                cap_idx <= cap_idx + 2'd1;
                if (cap_idx == 2'd3) state <= (state == S_CAP_WR) ? S_WR_RA : S_RD_STS;
`endif
              end else if (poll_met) begin
                poll_cnt <= '0;
                state    <= poll_next;
              end else if (poll_cnt_nxt == LIMIT_V) begin
                poll_cnt  <= '0;
                o_timeout <= 1'b1;
                o_pass    <= 1'b0;
                state     <= S_DONE;
              end else begin
                poll_cnt <= poll_cnt_nxt;
                gap_cnt  <= '0;
                ph       <= PH_GAP;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aximm_test_sequencer.sv
// Directed bench for aximm_test_sequencer: a scripted AVMM slave plus a transaction-list
// model of the expected register sequence and final grade for each scenario.
module tb_aximm_test_sequencer;
  localparam int GAP   = 4;
  localparam int LIMIT = 8;

  logic        avmm_clk = 1'b0;
  logic        avmm_rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_waitrequest = 1'b0;
  logic        i_readdatavalid = 1'b0;
  logic [31:0] i_readdata = 32'h0;
  logic [31:0] o_address, o_writedata;
  logic        o_write, o_read, o_busy, o_done, o_pass, o_timeout;
  logic [3:0]  o_status;

  aximm_test_sequencer #(.POLL_GAP(GAP), .POLL_LIMIT(LIMIT)) dut (
    .avmm_clk(avmm_clk), .avmm_rst(avmm_rst), .i_start(i_start),
    .o_address(o_address), .o_write(o_write), .o_read(o_read), .o_writedata(o_writedata),
    .i_waitrequest(i_waitrequest), .i_readdatavalid(i_readdatavalid), .i_readdata(i_readdata),
    .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass), .o_timeout(o_timeout),
    .o_status(o_status)
  );

  always #5 avmm_clk = ~avmm_clk;

  typedef struct packed { logic we; logic [31:0] addr; logic [31:0] data; } tx_t;

  int checks = 0;
  int errors = 0;

  // Scenario knobs and model (written by main only)
  int lf, wf, rf, wt;
  logic [3:0] sts_v;
  tx_t exp_q[$];
  logic exp_pass, exp_timeout;
  logic [3:0] exp_status;

  // Slave-owned observation state
  tx_t act_log[$];
  int link_rd, sts_rd, ntx, done_cnt, wcnt, last_link, cyc;
  bit pend, stalled;
  logic [31:0] pend_data, hold_addr, hold_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic tx_t mk(input logic we, input logic [31:0] a, input logic [31:0] d);
    tx_t t;
    t.we = we; t.addr = a; t.data = d;
    return t;
  endfunction

  // Appends a poll phase; returns 1 if it ends in a timeout.
  function automatic bit push_poll(input logic [31:0] a, input int fails);
    int n;
    n = (fails + 1 > LIMIT) ? LIMIT : fails + 1;
    for (int i = 0; i < n; i++) exp_q.push_back(mk(1'b0, a, 32'h0));
    return (fails >= LIMIT);
  endfunction

  function automatic void build();
    exp_q.delete();
    exp_pass = 1'b0; exp_timeout = 1'b1; exp_status = 4'h0;
    exp_q.push_back(mk(1'b1, 32'h50002000, 32'h0000000C));
    exp_q.push_back(mk(1'b1, 32'h50002004, 32'h00000020));
    exp_q.push_back(mk(1'b1, 32'h50002008, 32'h00001770));
    if (push_poll(32'h5000100C, lf)) return;
    exp_q.push_back(mk(1'b1, 32'h50001004, 32'h10000000));
    exp_q.push_back(mk(1'b1, 32'h50001000, 32'h00041804));
    if (push_poll(32'h50001008, wf)) return;
    exp_q.push_back(mk(1'b1, 32'h50001004, 32'h10000000));
    exp_q.push_back(mk(1'b1, 32'h50001010, 32'h00041804));
    if (push_poll(32'h50001008, rf)) return;
    exp_q.push_back(mk(1'b0, 32'h50001008, 32'h0));
    exp_timeout = 1'b0;
    exp_status  = sts_v;
    exp_pass    = (sts_v == 4'hF);
  endfunction

  function automatic logic [31:0] resp(input logic [31:0] a);
    logic [31:0] d;
    d = 32'h0;
    if (a == 32'h5000100C) begin
      d = (link_rd < lf) ? 32'h0 : 32'hF;
      link_rd++;
    end else if (a == 32'h50001008) begin
      if (sts_rd < wf)                d = 32'h00;
      else if (sts_rd == wf)          d = 32'h10;
      else if (sts_rd < wf + 1 + rf)  d = 32'h10;
      else if (sts_rd == wf + 1 + rf) d = 32'h30;
      else                            d = 32'h30 | {28'h0, sts_v};
      sts_rd++;
    end
    return d;
  endfunction

  // Slave and compare process: everything is evaluated on the falling edge.
  initial begin
    tx_t e;
    cyc = 0; pend = 0; stalled = 0; wcnt = 0; last_link = -1;
    link_rd = 0; sts_rd = 0; ntx = 0; done_cnt = 0;
    forever begin
      @(negedge avmm_clk);
      cyc++;
      i_readdatavalid = 1'b0;
      i_readdata      = 32'h0;
      if (avmm_rst) begin
        pend = 0; stalled = 0; wcnt = 0; i_waitrequest = 1'b0;
        continue;
      end
      if (i_start && !o_busy) begin
        link_rd = 0; sts_rd = 0; ntx = 0; done_cnt = 0; last_link = -1;
        act_log.delete();
      end
      if (o_done) begin
        done_cnt++;
        chk("busy_low_at_done", o_busy, 0);
      end
      if (pend) begin
        i_readdatavalid = 1'b1;
        i_readdata      = pend_data;
        pend = 0;
      end
      if (stalled) chk("strobe_held", o_read | o_write, 1);
      if (o_read || o_write) begin
        chk("rd_wr_exclusive", o_read & o_write, 0);
        chk("busy_during_cmd", o_busy, 1);
        if (wcnt == 0) begin
          hold_addr = o_address; hold_data = o_writedata;
        end else begin
          chk("addr_stable", o_address, hold_addr);
          chk("data_stable", o_writedata, hold_data);
        end
        if (wcnt < wt) begin
          i_waitrequest = 1'b1;
          wcnt++;
          stalled = 1;
        end else begin
          i_waitrequest = 1'b0;
          wcnt = 0;
          stalled = 0;
          act_log.push_back(mk(o_write, o_address, o_writedata));
          if (ntx < exp_q.size()) begin
            e = exp_q[ntx];
            chk("tx_kind", o_write, e.we);
            chk("tx_addr", o_address, e.addr);
            if (o_write) chk("tx_wdata", o_writedata, e.data);
          end else begin
            checks++; errors++;
            $display("FAIL unexpected_tx: got addr 0x%0h, model has only %0d", o_address, exp_q.size());
          end
          ntx++;
          if (o_read) begin
            if (o_address == 32'h5000100C) begin
              if (last_link >= 0) chk("link_poll_spacing_gt_gap", (cyc - last_link) > GAP, 1);
              last_link = cyc;
            end
            pend = 1;
            pend_data = resp(o_address);
          end
        end
      end else begin
        i_waitrequest = 1'b0;
        stalled = 0;
        wcnt = 0;
      end
    end
  end

  task automatic pulse_start();
    i_start = 1'b1;
    @(posedge avmm_clk); #2;
    i_start = 1'b0;
  endtask

  task automatic setup(input int lf_i, input int wf_i, input int rf_i,
                       input logic [3:0] sts_i, input int wt_i);
    @(posedge avmm_clk); #2;
    lf = lf_i; wf = wf_i; rf = rf_i; sts_v = sts_i; wt = wt_i;
    build();
  endtask

  task automatic run(input int lf_i, input int wf_i, input int rf_i,
                     input logic [3:0] sts_i, input int wt_i, input bit extra);
    bit got;
    setup(lf_i, wf_i, rf_i, sts_i, wt_i);
    pulse_start();
    chk("busy_after_start", o_busy, 1);
    if (extra) begin
      repeat (6) @(posedge avmm_clk);
      #2;
      pulse_start();
    end
    got = 0;
    for (int n = 0; n < 5000 && !got; n++) begin
      @(negedge avmm_clk);
      if (o_done) got = 1;
    end
    chk("done_seen", got, 1);
    repeat (3) @(negedge avmm_clk);
    chk("done_pulse_count", done_cnt, 1);
    chk("final_pass", o_pass, exp_pass);
    chk("final_timeout", o_timeout, exp_timeout);
    chk("final_status", o_status, exp_status);
    chk("idle_not_busy", o_busy, 0);
    chk("tx_count", ntx, exp_q.size());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    lf = 0; wf = 0; rf = 0; sts_v = 4'hF; wt = 0;
    repeat (3) @(posedge avmm_clk);
    #2;
    chk("rst_busy", o_busy, 0);
    chk("rst_write", o_write, 0);
    chk("rst_read", o_read, 0);
    chk("rst_addr", o_address, 0);
    chk("rst_done", o_done, 0);
    chk("rst_pass", o_pass, 0);
    chk("rst_timeout", o_timeout, 0);
    chk("rst_status", o_status, 0);
    avmm_rst = 1'b0;

    // 1: zero-wait, immediate success
    run(0, 0, 0, 4'hF, 0, 0);
    chk("t1_tx_total", ntx, 11);
    chk("t1_first_addr", act_log[0].addr, 32'h50002000);
    chk("t1_first_data", act_log[0].data, 32'h0000000C);
    chk("t1_y_data", act_log[1].data, 32'h00000020);
    chk("t1_z_data", act_log[2].data, 32'h00001770);
    chk("t1_pass", o_pass, 1);

    // 2: three wait cycles per command
    run(0, 0, 0, 4'hF, 3, 0);
    chk("t2_tx_total", ntx, 11);

    // 3: link up on the sixth poll
    run(5, 0, 0, 4'hF, 0, 0);
    chk("t3_link_reads", link_rd, 6);

    // 4: write-done never arrives
    run(0, 99, 0, 4'hF, 0, 0);
    chk("t4_status_reads", sts_rd, 8);
    chk("t4_timeout", o_timeout, 1);
    chk("t4_pass", o_pass, 0);

    // 5: failing status, redundant start while busy
    run(0, 1, 2, 4'hE, 1, 1);
    chk("t5_status", o_status, 4'hE);
    chk("t5_pass", o_pass, 0);

    // 6: reset while polling write-done, then rerun
    setup(0, 99, 0, 4'hF, 0);
    pulse_start();
    got = 0;
    for (int n = 0; n < 2000 && !got; n++) begin
      @(posedge avmm_clk);
      if (sts_rd >= 2) got = 1;
    end
    chk("t6_reached_poll_wr", got, 1);
    #2 avmm_rst = 1'b1;
    @(posedge avmm_clk); #1;
    chk("t6_rst_busy", o_busy, 0);
    chk("t6_rst_read", o_read, 0);
    chk("t6_rst_write", o_write, 0);
    chk("t6_rst_addr", o_address, 0);
    chk("t6_rst_timeout", o_timeout, 0);
    chk("t6_rst_done", o_done, 0);
    #1 avmm_rst = 1'b0;
    repeat (2) @(posedge avmm_clk);
    run(0, 0, 0, 4'hF, 0, 0);
    chk("t6_rerun_first_addr", act_log[0].addr, 32'h50002000);
    chk("t6_rerun_pass", o_pass, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
